// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
// State encodings, access-length codes and the length-to-byte-count helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0]  LEN_BYTE   = 2'b00;
  localparam logic [1:0]  LEN_HALF   = 2'b01;
  localparam logic [1:0]  LEN_WORD   = 2'b11;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Byte counter must reach nbytes+1 (5) for the read done cycle.
  localparam int CNT_W = 3;

  // Code 2'b10 is not a legal length and is treated as a word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer: per-transaction counter, base+count address generation and
// byte-by-byte word assembly in either big-endian or little-endian order.
module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              run,
  input  logic              capture,
  input  logic              big_endian,
  input  logic [7:0]        din,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       word_next
);

  logic [ADDR_W-1:0] base;
  logic [31:0]       acc;
  logic [1:0]        idx;
  logic [1:0]        pos;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      base <= '0;
      cnt  <= '0;
      acc  <= ZERO_WORD;
    end else if (start) begin
      base <= start_base;
      cnt  <= '0;
      acc  <= ZERO_WORD;
    end else begin
      if (run)     cnt <= cnt + 3'd1;
      if (capture) acc <= word_next;
    end
  end

  // Address arithmetic wraps naturally at the top of the address space.
  assign addr = base + ADDR_W'(cnt);

  // Byte captured at count c is byte c-1 of the transfer.
  always_comb begin
    word_next = acc;
    idx       = 2'(cnt - 3'd1);
    pos       = big_endian ? (2'd3 - idx) : idx;
    word_next[{pos, 3'b000} +: 8] = din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and MEM-stage
// loads/stores; MEM has priority, IF fetches may be aborted by if_flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IF_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  // Handshake: a requester raises req with stable operands and holds it until
  // its one-cycle done pulse; operands are latched at grant, so req may drop
  // or operands change afterwards without affecting the transfer.

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  nbytes, nbytes_grant, cnt;
  logic [ADDR_W-1:0] base_grant, seq_addr;
  logic [31:0]       wdata_q, word_next;
  logic              start, reading, capture, last_capture, rd_done, wr_done;

  assign reading      = (state == IF_RD) || (state == MEM_RD);
  assign capture      = reading && (cnt != '0) && (cnt <= nbytes);
  assign last_capture = capture && (cnt == nbytes);
  assign rd_done      = reading && (cnt == nbytes + 3'd1);
  assign wr_done      = (state == MEM_WR) && (cnt == nbytes);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IDLE;
      nbytes    <= '0;
      wdata_q   <= ZERO_WORD;
      if_rdata  <= ZERO_WORD;
      mem_rdata <= ZERO_WORD;
    end else begin
      state <= state_next;
      if (start) begin
        nbytes  <= nbytes_grant;
        wdata_q <= mem_wdata;
      end
      if (last_capture && (state == IF_RD) && !if_flush) if_rdata <= word_next;
      if (last_capture && (state == MEM_RD)) mem_rdata <= word_next;
    end
  end

  // A flush aborts a fetch up to its last capture; the done cycle always completes.
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    base_grant   = mem_addr;
    nbytes_grant = len_bytes(mem_len);
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_next = mem_we ? MEM_WR : MEM_RD;
          start      = 1'b1;
        end else if (if_req && !if_flush) begin
          state_next   = IF_RD;
          start        = 1'b1;
          base_grant   = if_addr;
          nbytes_grant = CNT_W'(IF_LEN);
        end
      end
      IF_RD:   if (rd_done || if_flush) state_next = IDLE;
      MEM_RD:  if (rd_done) state_next = IDLE;
      MEM_WR:  if (wr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_base (base_grant),
    .run        (busy),
    .capture    (capture),
    .big_endian (state == IF_RD),
    .din        (ram_din),
    .cnt        (cnt),
    .addr       (seq_addr),
    .word_next  (word_next)
  );

  assign busy     = (state != IDLE);
  assign if_done  = (state == IF_RD) && rd_done;
  assign mem_done = ((state == MEM_RD) && rd_done) || wr_done;
  assign ram_wr   = (state == MEM_WR) && (cnt < nbytes);
  assign ram_a    = busy ? seq_addr : '0;
  assign ram_dout = ram_wr ? wdata_q[{cnt[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between the instruction-fetch requester and the MEM-stage load/store requester.
- Performs multi-cycle byte sequencing and word assembly, and reports completion to each requester.
- Sits between the IF/MEM stages and the external RAM interface.
- The pipeline controller uses `if_done`, `mem_done` and `busy` to derive IF/ID halt and discard control.

Parameters:
- ADDR_W, 32, width of all address ports; ram_a is truncated externally.
- IF_LEN, 4, bytes per instruction fetch; fixed at 4 and not overridable in practice.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  abort an in-flight fetch (branch/jump taken).
- if_rdata  out  32  fetched word; byte at if_addr+0 in [31:24], +3 in [7:0].
- if_done  out  1  one-cycle pulse; if_rdata valid that cycle and held after.
- mem_req  in  1  load/store request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  00 byte, 01 half, 11 word; 10 treated as word.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  32  store data, little-endian (byte k = [8k+7:8k]).
- mem_rdata  out  32  load data, little-endian, zero-extended above mem_len.
- mem_done  out  1  one-cycle pulse on load/store completion.
- busy  out  1  high whenever state != IDLE.
- ram_din  in  8  RAM read byte, valid one cycle after address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  1 = write, 0 = read.

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE, byte counter=0.
  - Outputs cleared: if_done=0, mem_done=0, busy=0, ram_wr=0, ram_a=0, ram_dout=0, if_rdata=0, mem_rdata=0.
  - An in-flight transaction is dropped without a done pulse.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE arbitration, one grant per cycle:
  - mem_req has priority over if_req.
  - mem_req & mem_we -> MEM_WR.
  - mem_req & !mem_we -> MEM_RD.
  - else if_req & !if_flush -> IF_RD.
  - Request operands (addr, len, wdata) are latched at grant; later changes are ignored.
- Byte count N = 1, 2 or 4 from mem_len; IF always 4.
- Address k drives base+k, computed modulo 2^ADDR_W (wraps at top of address space).
- Read (IF_RD / MEM_RD):
  - Cycle 0 after grant drives ram_a=base+0, ram_wr=0.
  - Cycle c (1..N) captures ram_din as byte c-1; ram_a=base+c is driven while c<N.
  - Done pulses in the cycle after the last byte is captured.
  - Total latency from grant cycle to done: N+2 cycles (IF: 6).
  - Return to IDLE in the done cycle; a new grant is allowed on the next cycle.
- Write (MEM_WR):
  - Cycles 0..N-1 drive ram_a=base+k, ram_dout=wdata byte k, ram_wr=1.
  - ram_wr=0 and mem_done=1 on cycle N, then IDLE.
- Dropped requests:
  - If a requester deasserts req mid-transaction, the transaction still completes.
  - Exception: if_flush during IF_RD aborts. State goes to IDLE on the next edge, ram_wr stays 0, no if_done, if_rdata is unchanged.
  - if_flush in IDLE blocks the IF grant that cycle.
  - if_flush during MEM_* has no effect.
- Done timing: if_done and mem_done are never both high. Each done lasts exactly one cycle. rdata holds its value until the next done of the same requester.
- Starvation: an IF request waits while back-to-back MEM requests are granted. The pipeline guarantees a MEM request deasserts after its mem_done.

Decomposition:
- `define.v`:
  - state encodings (IDLE/IF_RD/MEM_RD/MEM_WR);
  - mem_len codes (LenByte, LenHalf, LenWord);
  - existing `RstEnable`, `ZeroWord`, `InstAddrBus`, `InstBus`.
- One sub-module is natural: mem_byte_seq (counter + address increment + byte shift/assemble, parameterised by packing order). It is instantiated once and muxed by state; the arbiter FSM stays in mem_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_a steps 0x100..0x103; if_done 6 cycles after grant; if_rdata=0x13050000.
- Simultaneous if_req and mem_req load word at 0x200 = AA,BB,CC,DD -> MEM granted first; mem_rdata=0xDDCCBBAA; IF granted the cycle after mem_done.
- Store half, mem_addr=0x1FFF, wdata=0x12345678 -> ram_wr=1 for 2 cycles, (0x1FFF,78) then (0x2000,56); mem_done on cycle 2.
- Load byte at 0xFFFFFFFF=0x80 -> mem_rdata=0x00000080; also word load at 0xFFFFFFFE wraps ram_a to 0x00000000.
- if_flush on cycle 2 of IF_RD -> IDLE next edge, no if_done, if_rdata unchanged; new if_req at 0x300 granted the following cycle.
- rst asserted mid MEM_WR (after 2 bytes) -> ram_wr=0, busy=0 next edge, no mem_done; a later request completes normally.
